// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle control unit (master) and the datapath/memory side (slave).
interface mc_control_fsm_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      Instruction_i;
  logic             MemReady_i;
  logic             BrTaken_i;
  logic             IRWrEn_o;
  logic             PCWrEn_o;
  logic [1:0]       PCSrc_o;
  logic             OffsetBase_o;
  logic             IorD_o;
  logic             MemRdEn_o;
  logic             MemWrEn_o;
  logic             ALUSrc_o;
  logic [1:0]       ALUOp_o;
  logic             MemtoReg_o;
  logic             PCtoReg_o;
  logic             RegWrEn_o;
  logic             Fault_o;
  logic             InstrRetired_o;
  logic [CNT_W-1:0] InstrCnt_o;
  logic [3:0]       State_o;

  modport master (
    input  Instruction_i, MemReady_i, BrTaken_i,
    output IRWrEn_o, PCWrEn_o, PCSrc_o, OffsetBase_o, IorD_o, MemRdEn_o, MemWrEn_o,
           ALUSrc_o, ALUOp_o, MemtoReg_o, PCtoReg_o, RegWrEn_o, Fault_o,
           InstrRetired_o, InstrCnt_o, State_o
  );

  modport slave (
    output Instruction_i, MemReady_i, BrTaken_i,
    input  IRWrEn_o, PCWrEn_o, PCSrc_o, OffsetBase_o, IorD_o, MemRdEn_o, MemWrEn_o,
           ALUSrc_o, ALUOp_o, MemtoReg_o, PCtoReg_o, RegWrEn_o, Fault_o,
           InstrRetired_o, InstrCnt_o, State_o
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control unit: fetch/decode/execute/memory/write-back sequencing with memory timeout.
// Optional macro CU_ILLEGAL_TRAP_EN: unrecognised opcodes trap to FAULT instead of retiring as a NOP.
module mc_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  mc_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_LUI    = 4'd4,
    S_WB_ALU = 4'd5,
    S_ADDR   = 4'd6,
    S_MEM_RD = 4'd7,
    S_WB_MEM = 4'd8,
    S_MEM_WR = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_FAULT  = 4'd15
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam int unsigned       WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic [CNT_W-1:0]  instrCnt_q, instrCnt_d;

  logic [6:0] opcode;
  logic       memState;
  logic       timeoutHit;
  logic       retire;
  logic       irWrEn, pcWrEn, offsetBase, iorD, memRdEn, memWrEn, aluSrc;
  logic       memtoReg, pcToReg, regWrEn;
  logic [1:0] pcSrc, aluOp;
  logic       unused_instr;

  assign opcode       = bus.Instruction_i[6:0];
  assign unused_instr = ^bus.Instruction_i[31:7];
  assign memState     = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // The last tolerated wait cycle is the one where the counter already holds MEM_TIMEOUT-1.
  assign timeoutHit   = (MEM_TIMEOUT != 0) && memState && !bus.MemReady_i && (waitCnt_q == WAIT_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_FETCH;
      waitCnt_q  <= '0;
      instrCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      instrCnt_q <= instrCnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (bus.MemReady_i)   state_d = S_DECODE;
        else if (timeoutHit)  state_d = S_FAULT;
      end
      S_DECODE: begin
        case (opcode)
          OP_R:              state_d = S_EXEC_R;
          OP_IMM:            state_d = S_EXEC_I;
          OP_LOAD, OP_STORE: state_d = S_ADDR;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_LUI:            state_d = S_LUI;
          OP_JAL, OP_JALR:   state_d = S_JUMP;
`ifdef CU_ILLEGAL_TRAP_EN
          default:           state_d = S_FAULT;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_LUI: state_d = S_WB_ALU;
      S_WB_ALU:                  state_d = S_FETCH;
      S_ADDR:                    state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (bus.MemReady_i)   state_d = S_WB_MEM;
        else if (timeoutHit)  state_d = S_FAULT;
      end
      S_WB_MEM:                  state_d = S_FETCH;
      S_MEM_WR: begin
        if (bus.MemReady_i)   state_d = S_FETCH;
        else if (timeoutHit)  state_d = S_FAULT;
      end
      S_BRANCH, S_JUMP:          state_d = S_FETCH;
      S_FAULT:                   state_d = S_FAULT;
      default:                   state_d = S_FAULT;
    endcase

    // Any state change restarts the wait count, so every memory state is entered with zero.
    if (state_d != state_q)                waitCnt_d = '0;
    else if (memState && !bus.MemReady_i)  waitCnt_d = waitCnt_q + 1'b1;
    else                                   waitCnt_d = waitCnt_q;

    instrCnt_d = instrCnt_q + CNT_W'(retire);
  end

  always_comb begin
    irWrEn     = 1'b0;
    pcWrEn     = 1'b0;
    pcSrc      = 2'b00;
    offsetBase = 1'b0;
    iorD       = 1'b0;
    memRdEn    = 1'b0;
    memWrEn    = 1'b0;
    aluSrc     = 1'b0;
    aluOp      = 2'b00;
    memtoReg   = 1'b0;
    pcToReg    = 1'b0;
    regWrEn    = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        memRdEn = 1'b1;
        irWrEn  = bus.MemReady_i;
        pcWrEn  = bus.MemReady_i;
      end
      S_DECODE: begin
        case (opcode)
          OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL, OP_JALR: ;
`ifdef CU_ILLEGAL_TRAP_EN
          default: ;
`else
          default: retire = 1'b1;
`endif
        endcase
      end
      S_EXEC_R: ;
      S_EXEC_I: aluSrc = 1'b1;
      S_LUI: begin
        aluSrc = 1'b1;
        aluOp  = 2'b11;
      end
      S_WB_ALU: begin
        regWrEn = 1'b1;
        retire  = 1'b1;
      end
      S_ADDR: begin
        aluSrc = 1'b1;
        aluOp  = 2'b01;
      end
      S_MEM_RD: begin
        memRdEn = 1'b1;
        iorD    = 1'b1;
      end
      S_WB_MEM: begin
        regWrEn  = 1'b1;
        memtoReg = 1'b1;
        retire   = 1'b1;
      end
      S_MEM_WR: begin
        memWrEn = 1'b1;
        iorD    = 1'b1;
        retire  = bus.MemReady_i;
      end
      S_BRANCH: begin
        aluOp  = 2'b10;
        pcSrc  = 2'b01;
        pcWrEn = bus.BrTaken_i;
        retire = 1'b1;
      end
      S_JUMP: begin
        regWrEn    = 1'b1;
        pcToReg    = 1'b1;
        pcWrEn     = 1'b1;
        pcSrc      = 2'b01;
        offsetBase = (opcode == OP_JALR);
        retire     = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.IRWrEn_o       = irWrEn;
  assign bus.PCWrEn_o       = pcWrEn;
  assign bus.PCSrc_o        = pcSrc;
  assign bus.OffsetBase_o   = offsetBase;
  assign bus.IorD_o         = iorD;
  assign bus.MemRdEn_o      = memRdEn;
  assign bus.MemWrEn_o      = memWrEn;
  assign bus.ALUSrc_o       = aluSrc;
  assign bus.ALUOp_o        = aluOp;
  assign bus.MemtoReg_o     = memtoReg;
  assign bus.PCtoReg_o      = pcToReg;
  assign bus.RegWrEn_o      = regWrEn;
  assign bus.Fault_o        = (state_q == S_FAULT);
  assign bus.InstrRetired_o = retire;
  assign bus.InstrCnt_o     = instrCnt_q;
  assign bus.State_o        = state_q;

endmodule
